sss_nid1_detector: RTL and testbench
====================================

Name: sss_nid1_detector

Overview:
- Secondary Synchronization Signal (SSS) detector for the 5G NR receiver PHY, per 3GPP TS 38.211 §7.4.2.3.
- Consumes the 127 hard-decided BPSK SSS bits from the FFT demodulator, plus the N_id_2 supplied by the PSS detector.
- Finds the best-matching N_id_1 (0..335) and reports N_id_1 and the combined cell ID N_id = 3·N_id_1 + N_id_2.
- Sits between FFT demodulation and the channel estimator.

Parameters:
- N_ID_1_MAX, 335, largest N_id_1; localparam.
- SSS_LEN, 127, SSS length in bits; localparam.
- N_ID_MAX, 1007, largest cell ID; localparam.

Ports:
- clk_i  in  1  single clock; all logic on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- N_id_2_i  in  2  PSS-derived N_id_2.
- N_id_2_valid_i  in  1  N_id_2_i qualifier.
- s_axis_in_tdata  in  1  SSS bit; 1 = positive BPSK symbol (+1), 0 = −1.
- s_axis_in_tvalid  in  1  bit qualifier.
- m_axis_out_tdata  out  9  detected N_id_1.
- m_axis_out_tvalid  out  1  one-cycle result strobe.
- N_id_o  out  10  3·N_id_1 + N_id_2.
- N_id_valid_o  out  1  same cycle as m_axis_out_tvalid.

Behaviour:
- Reset values: all outputs 0; stored N_id_2 = 0; bit counter = 0; state IDLE/COLLECT.
- N_id_2 capture:
  - On N_id_2_valid_i with N_id_2_i ≤ 2, store N_id_2_i; the value 3 is ignored.
  - Capture is allowed in any state.
  - The stored value is frozen into the search at the COLLECT→SEARCH transition.
- COLLECT:
  - Each cycle with s_axis_in_tvalid=1 stores one bit; the first bit is n=0.
  - tvalid gaps are allowed.
  - After the 127th bit is accepted, go to SEARCH next cycle.
- SEARCH:
  - Evaluate candidates N_id_1 = 0,1,…,335 in ascending order, one per clock (pipelining permitted).
  - m0 = 15·floor(N_id_1/112) + 5·N_id_2; m1 = N_id_1 mod 112.
  - Base sequences:
    - x0(i+7) = x0(i+4) xor x0(i)
    - x1(i+7) = x1(i+1) xor x1(i)
    - initial [x(6)..x(0)] = 0000001
    - Both are 127-bit constants; the generator may be elaborated at build time.
  - Expected bit e(n) = NOT(x0((n+m0) mod 127) xor x1((n+m1) mod 127)).
  - Score = popcount of positions where the received bit equals e(n), range 0..127, 7 bits.
  - Keep the maximum score under a strict greater-than compare, so ties keep the lowest N_id_1.
- Input bits presented during SEARCH are ignored.
- Result:
  - When the last candidate has been scored, pulse m_axis_out_tvalid and N_id_valid_o for exactly one cycle.
  - m_axis_out_tdata = best N_id_1; N_id_o = 3·best + frozen N_id_2.
  - Latency: at most 345 cycles from the acceptance of the 127th bit.
- After the result:
  - Return to COLLECT with the counter at 0.
  - tdata and N_id_o hold their values until the next result.
- Reset during COLLECT or SEARCH: abort immediately, no result pulse; the next 127 valid bits form a fresh frame.
- Arithmetic: mod-127 indices are computed without a divider (conditional subtract; m0 ≤ 40, m1 ≤ 111, n ≤ 126).

Test Plan:
- Ideal SSS for N_id_1=0, N_id_2=0, sent contiguously → single pulse, tdata=0, N_id_o=0, latency ≤345.
- N_id_2_valid with 2, then ideal SSS for N_id_1=335 → tdata=335, N_id_o=1007.
- N_id_2=1, SSS for N_id_1=112 with random 1–3 cycle tvalid gaps → tdata=112, N_id_o=337.
- N_id_2=0, SSS for N_id_1=200 with 20 bits inverted → tdata=200, N_id_o=600.
- reset_i asserted after 60 bits, then full SSS for N_id_1=57, N_id_2=2 → exactly one pulse, tdata=57, N_id_o=173.
- Two frames back-to-back (N_id_1=10, then 11), with N_id_2_valid 2 pulsed during the first search → results 10/30 then 11/35.

Source files
------------

// File: rtl/sss_nid1_detector.sv
// rtl/sss_nid1_detector.sv - NR SSS detector: collects 127 hard bits, searches N_id_1 0..335
// Reports the best-correlating N_id_1 and the combined cell ID 3*N_id_1 + N_id_2.
module sss_nid1_detector (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] N_id_2_i,
  input  logic       N_id_2_valid_i,
  input  logic       s_axis_in_tdata,
  input  logic       s_axis_in_tvalid,
  output logic [8:0] m_axis_out_tdata,
  output logic       m_axis_out_tvalid,
  output logic [9:0] N_id_o,
  output logic       N_id_valid_o
);

  localparam int N_ID_1_MAX = 335;
  localparam int SSS_LEN    = 127;
  localparam int N_ID_MAX   = 1007;
  localparam int NID_W      = $clog2(N_ID_MAX + 1);

  function automatic logic [126:0] gen_mseq(input int tap);
    logic [126:0] x;
    x    = '0;
    x[0] = 1'b1;
    for (int i = 0; i < SSS_LEN - 7; i++) x[i+7] = x[i+tap] ^ x[i];
    return x;
  endfunction

  localparam logic [126:0] X0 = gen_mseq(4);
  localparam logic [126:0] X1 = gen_mseq(1);

  typedef enum logic {S_COLLECT, S_SEARCH} state_t;

  state_t       r_state, w_next;
  logic [126:0] r_bits;
  logic [6:0]   r_cnt;
  logic [1:0]   r_n2, r_n2_frz;
  logic [8:0]   r_cand, r_best_id;
  logic [6:0]   r_best_score;

  logic [1:0]   w_q;
  logic [5:0]   w_m0;
  logic [6:0]   w_m1;
  logic [8:0]   w_off;
  logic [126:0] w_exp;
  logic [6:0]   w_score;
  logic         w_better;
  logic [8:0]   w_final;
  logic [NID_W-1:0] w_nid;
  logic [7:0]   w_s0, w_s1;
  logic [6:0]   w_i0, w_i1;

  always_comb begin
    w_q   = (r_cand >= 9'd224) ? 2'd2 : (r_cand >= 9'd112) ? 2'd1 : 2'd0;
    w_off = (w_q == 2'd2) ? 9'd224 : (w_q == 2'd1) ? 9'd112 : 9'd0;
    w_m1  = 7'(r_cand - w_off);
    w_m0  = ((w_q == 2'd2) ? 6'd30 : (w_q == 2'd1) ? 6'd15 : 6'd0) +
            ((r_n2_frz == 2'd2) ? 6'd10 : (r_n2_frz == 2'd1) ? 6'd5 : 6'd0);
  end

  // Expected sequence is the two m-sequences cyclically shifted; indices wrap with one subtract.
  always_comb begin
    w_exp   = '0;
    w_score = '0;
    w_s0    = '0;
    w_s1    = '0;
    w_i0    = '0;
    w_i1    = '0;
    for (int n = 0; n < SSS_LEN; n++) begin
      w_s0 = 8'(n) + {2'b00, w_m0};
      w_s1 = 8'(n) + {1'b0, w_m1};
      w_i0 = 7'((w_s0 >= 8'd127) ? (w_s0 - 8'd127) : w_s0);
      w_i1 = 7'((w_s1 >= 8'd127) ? (w_s1 - 8'd127) : w_s1);
      w_exp[n] = ~(X0[w_i0] ^ X1[w_i1]);
      w_score  = w_score + {6'd0, ~(r_bits[n] ^ w_exp[n])};
    end
  end

  assign w_better = (w_score > r_best_score);
  assign w_final  = w_better ? r_cand : r_best_id;
  assign w_nid    = NID_W'({w_final, 1'b0}) + NID_W'(w_final) + NID_W'(r_n2_frz);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_COLLECT: if (s_axis_in_tvalid && r_cnt == 7'(SSS_LEN - 1)) w_next = S_SEARCH;
      S_SEARCH:  if (r_cand == 9'(N_ID_1_MAX)) w_next = S_COLLECT;
      default:   w_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state           <= S_COLLECT;
      r_bits            <= '0;
      r_cnt             <= '0;
      r_n2              <= '0;
      r_n2_frz          <= '0;
      r_cand            <= '0;
      r_best_id         <= '0;
      r_best_score      <= '0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tvalid <= 1'b0;
      N_id_o            <= '0;
      N_id_valid_o      <= 1'b0;
    end else begin
      r_state           <= w_next;
      m_axis_out_tvalid <= 1'b0;
      N_id_valid_o      <= 1'b0;
      if (N_id_2_valid_i && N_id_2_i != 2'd3) r_n2 <= N_id_2_i;
      case (r_state)
        S_COLLECT: begin
          if (s_axis_in_tvalid) begin
            r_bits[r_cnt] <= s_axis_in_tdata;
            if (r_cnt == 7'(SSS_LEN - 1)) begin
              r_cnt        <= '0;
              r_n2_frz     <= r_n2;
              r_cand       <= '0;
              r_best_id    <= '0;
              r_best_score <= '0;
            end else begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
        end
        S_SEARCH: begin
          if (w_better) begin
            r_best_score <= w_score;
            r_best_id    <= r_cand;
          end
          r_cand <= r_cand + 9'd1;
          if (r_cand == 9'(N_ID_1_MAX)) begin
            m_axis_out_tdata  <= w_final;
            N_id_o            <= w_nid;
            m_axis_out_tvalid <= 1'b1;
            N_id_valid_o      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sss_nid1_detector.sv
// tb/tb_sss_nid1_detector.sv - directed bench for sss_nid1_detector
module tb_sss_nid1_detector;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [1:0] N_id_2_i;
  logic       N_id_2_valid_i;
  logic       s_axis_in_tdata;
  logic       s_axis_in_tvalid;
  logic [8:0] m_axis_out_tdata;
  logic       m_axis_out_tvalid;
  logic [9:0] N_id_o;
  logic       N_id_valid_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int t_last;
  int got_pulses, got_lat, got_tdata, got_nid, valid_mis;

  sss_nid1_detector dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .N_id_2_i          (N_id_2_i),
    .N_id_2_valid_i    (N_id_2_valid_i),
    .s_axis_in_tdata   (s_axis_in_tdata),
    .s_axis_in_tvalid  (s_axis_in_tvalid),
    .m_axis_out_tdata  (m_axis_out_tdata),
    .m_axis_out_tvalid (m_axis_out_tvalid),
    .N_id_o            (N_id_o),
    .N_id_valid_o      (N_id_valid_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  function automatic logic [126:0] sss_bits(input int nid1, input int nid2);
    int x0[127];
    int x1[127];
    int m0, m1;
    logic [126:0] b;
    for (int i = 0; i < 127; i++) begin x0[i] = 0; x1[i] = 0; end
    x0[0] = 1; x1[0] = 1;
    for (int i = 0; i < 120; i++) begin
      x0[i+7] = (x0[i+4] + x0[i]) % 2;
      x1[i+7] = (x1[i+1] + x1[i]) % 2;
    end
    m0 = 15 * (nid1 / 112) + 5 * nid2;
    m1 = nid1 % 112;
    for (int n = 0; n < 127; n++)
      b[n] = (x0[(n + m0) % 127] == x1[(n + m1) % 127]);
    return b;
  endfunction

  task automatic apply_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic set_n2(input int v);
    N_id_2_i = 2'(v); N_id_2_valid_i = 1'b1;
    @(negedge clk_i);
    N_id_2_valid_i = 1'b0;
  endtask

  task automatic drive_frame(input int nid1, input int nid2, input bit gaps,
                             input int nflip, input int nbits);
    logic [126:0] b;
    b = sss_bits(nid1, nid2);
    for (int k = 0; k < nflip; k++) b[6*k] = ~b[6*k];
    for (int n = 0; n < nbits; n++) begin
      if (gaps) begin
        s_axis_in_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk_i);
      end
      s_axis_in_tvalid = 1'b1;
      s_axis_in_tdata  = b[n];
      @(negedge clk_i);
    end
    s_axis_in_tvalid = 1'b0;
    t_last = cyc;
  endtask

  // Junk bits keep flowing during the search; they must be ignored.
  task automatic wait_result(input int n2_pulse_at);
    int k, extra;
    bit seen;
    got_pulses = 0; got_lat = -1; got_tdata = -1; got_nid = -1; valid_mis = 0;
    k = 0; extra = 0; seen = 0;
    while (k < 400 && extra < 6) begin
      s_axis_in_tvalid = !seen && (k % 3 == 0);
      s_axis_in_tdata  = 1'(k);
      N_id_2_valid_i   = (n2_pulse_at > 0 && k == n2_pulse_at);
      N_id_2_i         = 2'd2;
      @(negedge clk_i);
      k++;
      if (N_id_valid_o !== m_axis_out_tvalid) valid_mis++;
      if (m_axis_out_tvalid === 1'b1) begin
        if (!seen) begin
          got_lat = cyc - t_last; got_tdata = m_axis_out_tdata; got_nid = N_id_o;
        end
        got_pulses++;
        seen = 1;
      end
      if (seen) extra++;
    end
    s_axis_in_tvalid = 1'b0;
    N_id_2_valid_i   = 1'b0;
  endtask

  task automatic check_frame(input string name, input int exp_id, input int exp_nid);
    tests_run++;
    if (got_pulses !== 1) begin tests_failed++;
      $display("FAIL %s pulses: got %0d expected 1", name, got_pulses); end
    tests_run++;
    if (got_tdata !== exp_id) begin tests_failed++;
      $display("FAIL %s tdata: got %0d expected %0d", name, got_tdata, exp_id); end
    tests_run++;
    if (got_nid !== exp_nid) begin tests_failed++;
      $display("FAIL %s N_id: got %0d expected %0d", name, got_nid, exp_nid); end
    tests_run++;
    if (got_lat < 1 || got_lat > 345 || valid_mis != 0) begin tests_failed++;
      $display("FAIL %s latency/valid: got lat %0d mis %0d expected lat 1..345 mis 0",
               name, got_lat, valid_mis); end
  endtask

  task automatic test_reset();
    N_id_2_i = 2'd0; N_id_2_valid_i = 1'b0;
    s_axis_in_tdata = 1'b0; s_axis_in_tvalid = 1'b0;
    apply_reset();
    tests_run++;
    if (m_axis_out_tvalid !== 1'b0 || N_id_valid_o !== 1'b0) begin tests_failed++;
      $display("FAIL reset valids: got %b/%b expected 0/0", m_axis_out_tvalid, N_id_valid_o); end
    tests_run++;
    if (m_axis_out_tdata !== 9'd0) begin tests_failed++;
      $display("FAIL reset tdata: got %0d expected 0", m_axis_out_tdata); end
    tests_run++;
    if (N_id_o !== 10'd0) begin tests_failed++;
      $display("FAIL reset N_id: got %0d expected 0", N_id_o); end
  endtask

  task automatic test_nid1_0();
    drive_frame(0, 0, 1'b0, 0, 127);
    wait_result(0);
    check_frame("nid1_0", 0, 0);
  endtask

  task automatic test_nid1_max();
    set_n2(2);
    drive_frame(335, 2, 1'b0, 0, 127);
    wait_result(0);
    check_frame("nid1_335", 335, 1007);
    tests_run++;
    if (m_axis_out_tdata !== 9'd335 || N_id_o !== 10'd1007) begin tests_failed++;
      $display("FAIL hold: got %0d/%0d expected 335/1007", m_axis_out_tdata, N_id_o); end
  endtask

  task automatic test_gaps();
    set_n2(1);
    set_n2(3);
    drive_frame(112, 1, 1'b1, 0, 127);
    wait_result(0);
    check_frame("gaps_112", 112, 337);
  endtask

  task automatic test_errors();
    set_n2(0);
    drive_frame(200, 0, 1'b0, 20, 127);
    wait_result(0);
    check_frame("errors_200", 200, 600);
  endtask

  task automatic test_abort();
    set_n2(2);
    drive_frame(57, 2, 1'b0, 0, 60);
    apply_reset();
    set_n2(2);
    drive_frame(57, 2, 1'b0, 0, 127);
    wait_result(0);
    check_frame("abort_57", 57, 173);
  endtask

  task automatic test_back_to_back();
    set_n2(0);
    drive_frame(10, 0, 1'b0, 0, 127);
    wait_result(50);
    check_frame("b2b_10", 10, 30);
    drive_frame(11, 2, 1'b0, 0, 127);
    wait_result(0);
    check_frame("b2b_11", 11, 35);
  endtask

  initial begin
    reset_i = 1'b1;
    test_reset();
    test_nid1_0();
    test_nid1_max();
    test_gaps();
    test_errors();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
